// File: rtl/mc_control.sv
// mc_control: multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// All outputs are registered: a strobe decided in a given cycle is visible
// during the following cycle (the cycle of the state being entered).
// Optional feature: define OVERFLOW_TRAP_EN to trap on add-class overflow.
module mc_control #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  input  logic        overflow,
  output logic [5:0]  alu_control,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  pc_src,
  output logic        exception,
  output logic [1:0]  exc_cause,
  output logic [2:0]  state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // A wait cycle that starts with the counter here would make it reach TIMEOUT.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] PC_SEQ     = 2'd0;
  localparam logic [1:0] PC_BRANCH  = 2'd1;
  localparam logic [1:0] PC_JUMP    = 2'd2;

  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_BUS      = 2'd2;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // Instruction class remembered from DECODE, since instr is only valid there.
  typedef enum logic [1:0] {
    K_ALU    = 2'd0,
    K_BRANCH = 2'd1,
    K_LOAD   = 2'd2,
    K_STORE  = 2'd3
  } kind_t;

  state_t           state_q;
  kind_t            kind_q;
  logic [5:0]       alu_q;
  logic [CNT_W-1:0] wait_q;
  logic             ir_write_q;
  logic             pc_write_q;
  logic             reg_write_q;
  logic             mem_read_q;
  logic             mem_write_q;
  logic [1:0]       pc_src_q;
  logic             exception_q;
  logic [1:0]       exc_cause_q;

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic [5:0] dec_alu_s;
  kind_t      dec_kind_s;
  logic       dec_legal_s;
  logic       dec_jump_s;
  logic       ovf_trap_s;
  logic       unused_s;

  assign opcode_s = instr[31:26];
  assign funct_s  = instr[5:0];

  // Opcode/funct decode; only consumed while in DECODE.
  always_comb begin
    dec_alu_s   = 6'd0;
    dec_kind_s  = K_ALU;
    dec_legal_s = 1'b1;
    dec_jump_s  = 1'b0;
    case (opcode_s)
      6'd0: begin
        case (funct_s)
          6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42: dec_alu_s = funct_s;
          default: dec_legal_s = 1'b0;
        endcase
      end
      6'd8, 6'd10, 6'd12, 6'd13: dec_alu_s = opcode_s;
      6'd15: dec_alu_s = 6'd9;
      6'd1, 6'd4, 6'd5: begin
        dec_alu_s  = opcode_s;
        dec_kind_s = K_BRANCH;
      end
      6'd35: begin
        dec_alu_s  = 6'd32;
        dec_kind_s = K_LOAD;
      end
      6'd43: begin
        dec_alu_s  = 6'd32;
        dec_kind_s = K_STORE;
      end
      6'd2: dec_jump_s = 1'b1;
      default: dec_legal_s = 1'b0;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  // Any add-class operation (alu 32 or 8) that overflows in EXEC traps,
  // including the lw/sw address add.
  assign ovf_trap_s = overflow && ((alu_q == 6'd32) || (alu_q == 6'd8));
  assign unused_s   = ^instr[25:6];
`else
  assign ovf_trap_s = 1'b0;
  assign unused_s   = ^{instr[25:6], overflow};
`endif

  // Single registered FSM: state, wait counter, latched decode and all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      kind_q      <= K_ALU;
      alu_q       <= 6'd0;
      wait_q      <= '0;
      ir_write_q  <= 1'b0;
      pc_write_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      pc_src_q    <= PC_SEQ;
      exception_q <= 1'b0;
      exc_cause_q <= 2'd0;
    end else begin
      // Strobes are single-cycle unless a state explicitly re-asserts them.
      ir_write_q  <= 1'b0;
      pc_write_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      pc_src_q    <= PC_SEQ;
      case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            ir_write_q <= 1'b1;
            pc_write_q <= 1'b1;
            state_q    <= S_DECODE;
          end else if (wait_q == LAST_WAIT) begin
            state_q     <= S_TRAP;
            exception_q <= 1'b1;
            exc_cause_q <= CAUSE_BUS;
          end else begin
            wait_q     <= wait_q + 1'b1;
            mem_read_q <= 1'b1;
          end
        end
        S_DECODE: begin
          alu_q  <= dec_alu_s;
          kind_q <= dec_kind_s;
          if (!dec_legal_s) begin
            state_q     <= S_TRAP;
            exception_q <= 1'b1;
            exc_cause_q <= CAUSE_ILLEGAL;
          end else if (dec_jump_s) begin
            pc_write_q <= 1'b1;
            pc_src_q   <= PC_JUMP;
            state_q    <= S_FETCH;
            wait_q     <= '0;
            mem_read_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (ovf_trap_s) begin
            state_q     <= S_TRAP;
            exception_q <= 1'b1;
            exc_cause_q <= CAUSE_OVERFLOW;
          end else begin
            case (kind_q)
              K_BRANCH: begin
                pc_write_q <= zero;
                pc_src_q   <= zero ? PC_BRANCH : PC_SEQ;
                state_q    <= S_FETCH;
                wait_q     <= '0;
                mem_read_q <= 1'b1;
              end
              K_LOAD: begin
                state_q    <= S_MEM;
                wait_q     <= '0;
                mem_read_q <= 1'b1;
              end
              K_STORE: begin
                state_q     <= S_MEM;
                wait_q      <= '0;
                mem_write_q <= 1'b1;
              end
              default: begin
                state_q     <= S_WB;
                reg_write_q <= 1'b1;
              end
            endcase
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (kind_q == K_LOAD) begin
              state_q     <= S_WB;
              reg_write_q <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              wait_q     <= '0;
              mem_read_q <= 1'b1;
            end
          end else if (wait_q == LAST_WAIT) begin
            state_q     <= S_TRAP;
            exception_q <= 1'b1;
            exc_cause_q <= CAUSE_BUS;
          end else begin
            wait_q      <= wait_q + 1'b1;
            mem_read_q  <= (kind_q == K_LOAD);
            mem_write_q <= (kind_q == K_STORE);
          end
        end
        S_WB: begin
          state_q    <= S_FETCH;
          wait_q     <= '0;
          mem_read_q <= 1'b1;
        end
        S_TRAP: begin
          // Sticky until reset; exception and cause hold, strobes stay low.
          state_q <= S_TRAP;
        end
        default: begin
          state_q <= S_FETCH;
          wait_q  <= '0;
        end
      endcase
    end
  end

  assign alu_control = alu_q;
  assign ir_write    = ir_write_q;
  assign pc_write    = pc_write_q;
  assign reg_write   = reg_write_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign pc_src      = pc_src_q;
  assign exception   = exception_q;
  assign exc_cause   = exc_cause_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed testbench for mc_control. Cycle n is the cycle in which the FSM
// sits in its n-th state after reset release; outputs are sampled 1 time unit
// after the edge that starts that cycle.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic        zero;
  logic        overflow;
  logic [5:0]  alu_control;
  logic        ir_write, pc_write, reg_write, mem_read, mem_write;
  logic [1:0]  pc_src;
  logic        exception;
  logic [1:0]  exc_cause;
  logic [2:0]  state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] got, exp;

  mc_control #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .zero(zero), .overflow(overflow), .alu_control(alu_control),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .pc_src(pc_src),
    .exception(exception), .exc_cause(exc_cause), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; overflow = 1'b0; instr = 32'h0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; overflow = 1'b1; instr = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      got = 32'({alu_control, ir_write, pc_write, reg_write, mem_read, mem_write,
                 pc_src, exception, exc_cause, state});
      exp = 32'h0; n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL reset_outputs[%0d]: got 0x%0h expected 0x%0h", i, got, exp); end
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    do_reset(); instr = 32'h012A_4020; mem_ready = 1'b1;
    step();
    got = 32'({state, ir_write, pc_write, pc_src, mem_read}); exp = 32'({3'd1, 1'b1, 1'b1, 2'd0, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL add_decode: got 0x%0h expected 0x%0h", got, exp); end
    step();
    got = 32'({state, alu_control, ir_write, pc_write}); exp = 32'({3'd2, 6'd32, 1'b0, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL add_exec: got 0x%0h expected 0x%0h", got, exp); end
    step();
    got = 32'({state, reg_write}); exp = 32'({3'd4, 1'b1}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL add_wb_cycle4: got 0x%0h expected 0x%0h", got, exp); end
    step();
    got = 32'({state, reg_write, mem_read, alu_control}); exp = 32'({3'd0, 1'b0, 1'b1, 6'd32}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL add_refetch: got 0x%0h expected 0x%0h", got, exp); end
  endtask

  task automatic test_back_to_back_branch();
    do_reset(); instr = 32'h1000_0003; mem_ready = 1'b1; zero = 1'b1;
    step(); step();
    got = 32'({state, alu_control, pc_write}); exp = 32'({3'd2, 6'd4, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL beq_exec: got 0x%0h expected 0x%0h", got, exp); end
    step();
    got = 32'({state, pc_write, pc_src}); exp = 32'({3'd0, 1'b1, 2'd1}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL beq_taken: got 0x%0h expected 0x%0h", got, exp); end
    zero = 1'b0;
    step();
    got = 32'({state, ir_write, pc_src}); exp = 32'({3'd1, 1'b1, 2'd0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL beq2_decode: got 0x%0h expected 0x%0h", got, exp); end
    step(); step();
    got = 32'({state, pc_write, pc_src}); exp = 32'({3'd0, 1'b0, 2'd0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL beq_not_taken: got 0x%0h expected 0x%0h", got, exp); end
  endtask

  task automatic test_jump();
    do_reset(); instr = 32'h0800_0010; mem_ready = 1'b1;
    step();
    got = 32'(state); exp = 32'd1; n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL j_decode: got 0x%0h expected 0x%0h", got, exp); end
    step();
    got = 32'({state, pc_write, pc_src, mem_read}); exp = 32'({3'd0, 1'b1, 2'd2, 1'b1}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL j_pc_write: got 0x%0h expected 0x%0h", got, exp); end
  endtask

  task automatic test_lw_wait();
    do_reset(); instr = 32'h8C00_0004; mem_ready = 1'b1;
    step(); step();
    mem_ready = 1'b0;
    for (int c = 4; c <= 7; c++) begin
      step();
      got = 32'({state, mem_read, mem_write, alu_control}); exp = 32'({3'd3, 1'b1, 1'b0, 6'd32}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL lw_mem_cycle%0d: got 0x%0h expected 0x%0h", c, got, exp); end
    end
    mem_ready = 1'b1;
    step();
    got = 32'({state, reg_write, mem_read, exception}); exp = 32'({3'd4, 1'b1, 1'b0, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL lw_wb_cycle8: got 0x%0h expected 0x%0h", got, exp); end
    step();
    got = 32'({state, reg_write}); exp = 32'({3'd0, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL lw_refetch: got 0x%0h expected 0x%0h", got, exp); end
  endtask

  task automatic test_sw();
    do_reset(); instr = 32'hAC00_0008; mem_ready = 1'b1;
    step(); step(); step();
    got = 32'({state, mem_write, mem_read}); exp = 32'({3'd3, 1'b1, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL sw_mem: got 0x%0h expected 0x%0h", got, exp); end
    step();
    got = 32'({state, mem_write, mem_read, reg_write}); exp = 32'({3'd0, 1'b0, 1'b1, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL sw_done_cycle5: got 0x%0h expected 0x%0h", got, exp); end
  endtask

  task automatic test_timeout_boundary();
    do_reset(); instr = 32'h012A_4020; mem_ready = 1'b0;
    repeat (14) step();
    got = 32'({state, mem_read, exception}); exp = 32'({3'd0, 1'b1, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL fetch_wait15: got 0x%0h expected 0x%0h", got, exp); end
    mem_ready = 1'b1;
    step();
    got = 32'({state, exception, ir_write}); exp = 32'({3'd1, 1'b0, 1'b1}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL ready_wins_at_limit: got 0x%0h expected 0x%0h", got, exp); end
  endtask

  task automatic test_fetch_timeout();
    do_reset(); instr = 32'h012A_4020; mem_ready = 1'b0;
    repeat (15) step();
    got = 32'({state, exception, exc_cause, mem_read}); exp = 32'({3'd5, 1'b1, 2'd2, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL fetch_timeout: got 0x%0h expected 0x%0h", got, exp); end
    mem_ready = 1'b1;
    repeat (3) step();
    got = 32'({state, exception, exc_cause, ir_write, pc_write}); exp = 32'({3'd5, 1'b1, 2'd2, 1'b0, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL trap_hold: got 0x%0h expected 0x%0h", got, exp); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    got = 32'({state, exception, exc_cause}); exp = 32'h0; n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL trap_reset: got 0x%0h expected 0x%0h", got, exp); end
  endtask

  task automatic test_mem_timeout();
    do_reset(); instr = 32'hAC00_0008; mem_ready = 1'b1;
    step(); step();
    mem_ready = 1'b0;
    repeat (15) step();
    got = 32'({state, mem_write, exception}); exp = 32'({3'd3, 1'b1, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL mem_wait_cycle18: got 0x%0h expected 0x%0h", got, exp); end
    step();
    got = 32'({state, exception, exc_cause, mem_write}); exp = 32'({3'd5, 1'b1, 2'd2, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL mem_timeout: got 0x%0h expected 0x%0h", got, exp); end
  endtask

  task automatic test_illegal();
    do_reset(); instr = 32'hFC00_0000; mem_ready = 1'b1;
    step(); step();
    got = 32'({state, exception, exc_cause, reg_write}); exp = 32'({3'd5, 1'b1, 2'd1, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL illegal_opcode: got 0x%0h expected 0x%0h", got, exp); end
    step(); step();
    got = 32'({state, reg_write, mem_read}); exp = 32'({3'd5, 1'b0, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL illegal_hold: got 0x%0h expected 0x%0h", got, exp); end
    do_reset(); instr = 32'h0000_0021; mem_ready = 1'b1;
    step(); step();
    got = 32'({state, exception, exc_cause}); exp = 32'({3'd5, 1'b1, 2'd1}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL illegal_funct: got 0x%0h expected 0x%0h", got, exp); end
  endtask

  task automatic test_decode_table();
    logic [31:0] vec_instr [16];
    logic [5:0]  vec_alu   [16];
    vec_instr = '{32'h2000_0000, 32'h2800_0000, 32'h3000_0000, 32'h3400_0000,
                  32'h3C00_0000, 32'h1000_0000, 32'h1400_0000, 32'h0400_0000,
                  32'h8C00_0000, 32'hAC00_0000, 32'h0000_0020, 32'h0000_0022,
                  32'h0000_0024, 32'h0000_0025, 32'h0000_0027, 32'h0000_002A};
    vec_alu   = '{6'd8, 6'd10, 6'd12, 6'd13, 6'd9, 6'd4, 6'd5, 6'd1,
                  6'd32, 6'd32, 6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
    for (int i = 0; i < 16; i++) begin
      do_reset(); instr = vec_instr[i]; mem_ready = 1'b1;
      step(); step();
      got = 32'({state, alu_control, exception}); exp = 32'({3'd2, vec_alu[i], 1'b0}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL decode_alu[%0d]: got 0x%0h expected 0x%0h", i, got, exp); end
    end
  endtask

  task automatic test_overflow();
    do_reset(); instr = 32'h2000_0001; mem_ready = 1'b1; overflow = 1'b1;
    step(); step(); step();
`ifdef OVERFLOW_TRAP_EN
    got = 32'({state, reg_write, exception, exc_cause}); exp = 32'({3'd5, 1'b0, 1'b1, 2'd3}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL addi_overflow_trap: got 0x%0h expected 0x%0h", got, exp); end
`else
    got = 32'({state, reg_write, exception, exc_cause}); exp = 32'({3'd4, 1'b1, 1'b0, 2'd0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL addi_overflow_ignored: got 0x%0h expected 0x%0h", got, exp); end
`endif
    do_reset(); instr = 32'h3400_0001; mem_ready = 1'b1; overflow = 1'b1;
    step(); step(); step();
    got = 32'({state, reg_write, exception}); exp = 32'({3'd4, 1'b1, 1'b0}); n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL ori_overflow_ignored: got 0x%0h expected 0x%0h", got, exp); end
    overflow = 1'b0;
  endtask

  initial begin
    reset = 1'b1; instr = 32'h0; mem_ready = 1'b0; zero = 1'b0; overflow = 1'b0;
    test_reset();
    test_add();
    test_back_to_back_branch();
    test_jump();
    test_lw_wait();
    test_sw();
    test_timeout_boundary();
    test_fetch_timeout();
    test_mem_timeout();
    test_illegal();
    test_decode_table();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
